tv_recorder: RTL and testbench

//  Synthesizable test-vector capture buffer. Samples DUT inputs and output {a,b,y} each

---
 rtl/tv_recorder.sv | 177 +++++++++++++++++
 tb/tb_tv_recorder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tv_recorder.sv
// Test-vector capture buffer: records {a,b,y} while armed, then streams the stored
// words back out over a valid/ready port in capture order.
module tv_recorder #(
    parameter  int WIDTH_IN  = 8,
    parameter  int WIDTH_OUT = 9,
    parameter  int DEPTH     = 1024,
    localparam int VEC_W     = 2 * WIDTH_IN + WIDTH_OUT,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 sample_en,
    input  logic [WIDTH_IN-1:0]  a,
    input  logic [WIDTH_IN-1:0]  b,
    input  logic [WIDTH_OUT-1:0] y,
    input  logic                 dump_ready,
    output logic                 dump_valid,
    output logic [VEC_W-1:0]     dump_data,
    output logic                 dump_last,
    output logic [CNT_W-1:0]     count,
    output logic                 full,
    output logic                 busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DUMP    = 2'd2;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C   = CNT_W'(0);
    localparam logic [AW-1:0]    WR_ONE_C = AW'(1);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [AW-1:0]    wr_ptr_r;
    logic [CNT_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             full_r;
    logic             busy_r;
    logic             dump_valid_r;
    logic [VEC_W-1:0] dump_data_r;
    logic             dump_last_r;

    logic [VEC_W-1:0] mem_r [DEPTH];

    logic             wr_en_s;
    logic [CNT_W-1:0] count_inc_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic             load_s;
    logic             beat_done_s;

    // Datapath qualifiers shared by the FSM and the register update.
    always_comb begin
        wr_en_s     = (state_r == ST_CAPTURE) && sample_en && !full_r;
        count_inc_s = count_r + ONE_C;
        if (wr_en_s) begin
            count_nxt_s = count_inc_s;
        end else begin
            count_nxt_s = count_r;
        end
        // Prefetch the next word whenever the output slot is empty or being drained.
        load_s      = (state_r == ST_DUMP) && (rd_ptr_r < count_r) &&
                      (!dump_valid_r || dump_ready);
        beat_done_s = dump_valid_r && dump_ready;
    end

    // Next-state logic for IDLE -> CAPTURE -> DUMP -> IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_CAPTURE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (wr_en_s && (count_inc_s == DEPTH_C)) begin
                    state_nxt_s = ST_DUMP;
                end else if (stop) begin
                    if (count_nxt_s == ZERO_C) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DUMP;
                    end
                end else begin
                    state_nxt_s = ST_CAPTURE;
                end
            end
            ST_DUMP: begin
                if (beat_done_s && dump_last_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DUMP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Vector storage; contents are only ever read back after being written this run.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= {a, b, y};
        end
    end

    // Control state, pointers, counters and the registered dump port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            full_r       <= 1'b0;
            dump_valid_r <= 1'b0;
            dump_data_r  <= '0;
            dump_last_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        wr_ptr_r <= '0;
                        rd_ptr_r <= '0;
                        count_r  <= '0;
                        full_r   <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    if (wr_en_s) begin
                        wr_ptr_r <= wr_ptr_r + WR_ONE_C;
                        count_r  <= count_inc_s;
                        full_r   <= (count_inc_s == DEPTH_C);
                    end
                    if (state_nxt_s == ST_DUMP) begin
                        rd_ptr_r <= '0;
                    end
                end
                ST_DUMP: begin
                    if (load_s) begin
                        dump_data_r  <= mem_r[rd_ptr_r[AW-1:0]];
                        dump_last_r  <= (rd_ptr_r == (count_r - ONE_C));
                        dump_valid_r <= 1'b1;
                        rd_ptr_r     <= rd_ptr_r + ONE_C;
                    end else if (beat_done_s) begin
                        // Only the final beat can drain without a follow-on word.
                        dump_valid_r <= 1'b0;
                        dump_last_r  <= 1'b0;
                        dump_data_r  <= '0;
                    end
                end
                default: begin
                    dump_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign dump_valid = dump_valid_r;
    assign dump_data  = dump_data_r;
    assign dump_last  = dump_last_r;
    assign count      = count_r;
    assign full       = full_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_tv_recorder.sv
// Bench for tv_recorder: a DEPTH=1024 and a DEPTH=4 instance checked each cycle
// against a queue-style capture/dump model, plus literal expectations per scenario.
module tb_tv_recorder;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic       start_big, start_sml, stop, sample_en, dump_ready;
    logic [7:0] a, b;
    logic [8:0] y;

    logic        dv_big, dl_big, full_big, busy_big;
    logic [24:0] dd_big;
    logic [10:0] cnt_big;
    logic        dv_sml, dl_sml, full_sml, busy_sml;
    logic [24:0] dd_sml;
    logic [2:0]  cnt_sml;

    tv_recorder #(.WIDTH_IN(8), .WIDTH_OUT(9), .DEPTH(1024)) u_big (
        .clk(clk), .reset(reset), .start(start_big), .stop(stop), .sample_en(sample_en),
        .a(a), .b(b), .y(y), .dump_ready(dump_ready), .dump_valid(dv_big),
        .dump_data(dd_big), .dump_last(dl_big), .count(cnt_big), .full(full_big),
        .busy(busy_big));

    tv_recorder #(.WIDTH_IN(8), .WIDTH_OUT(9), .DEPTH(4)) u_sml (
        .clk(clk), .reset(reset), .start(start_sml), .stop(stop), .sample_en(sample_en),
        .a(a), .b(b), .y(y), .dump_ready(dump_ready), .dump_valid(dv_sml),
        .dump_data(dd_sml), .dump_last(dl_sml), .count(cnt_sml), .full(full_sml),
        .busy(busy_sml));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, inst, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 capturing, 2 entering dump, 3 presenting word midx.
    int          mdepth [2] = '{1024, 4};
    int          mphase [2];
    int          msize  [2];
    int          midx   [2];
    logic [24:0] mword  [2][1024];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                mphase[i] = 0;
                msize[i]  = 0;
                midx[i]   = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic st;
                st = (i == 0) ? start_big : start_sml;
                case (mphase[i])
                    0: if (st) begin msize[i] = 0; mphase[i] = 1; end
                    1: begin
                        if (sample_en && msize[i] < mdepth[i]) begin
                            mword[i][msize[i]] = {a, b, y};
                            msize[i]++;
                        end
                        if (msize[i] == mdepth[i]) mphase[i] = 2;
                        else if (stop) mphase[i] = (msize[i] == 0) ? 0 : 2;
                    end
                    2: begin mphase[i] = 3; midx[i] = 0; end
                    3: if (dump_ready) begin
                        midx[i]++;
                        if (midx[i] == msize[i]) mphase[i] = 0;
                    end
                    default: mphase[i] = 0;
                endcase
            end
        end
    end

    // Handshaked words per instance, in arrival order.
    logic [24:0] rxw [2][16];
    int          rxn [2];

    logic        o_dv, o_dl, o_full, o_busy;
    logic [24:0] o_dd;
    logic [10:0] o_cnt;

    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                if (i == 0) begin
                    o_dv = dv_big; o_dl = dl_big; o_full = full_big; o_busy = busy_big;
                    o_dd = dd_big; o_cnt = cnt_big;
                end else begin
                    o_dv = dv_sml; o_dl = dl_sml; o_full = full_sml; o_busy = busy_sml;
                    o_dd = dd_sml; o_cnt = {8'd0, cnt_sml};
                end
                check("busy", i, {31'd0, o_busy}, {31'd0, mphase[i] != 0});
                check("count", i, {21'd0, o_cnt}, msize[i]);
                check("full", i, {31'd0, o_full}, {31'd0, msize[i] == mdepth[i]});
                check("dump_valid", i, {31'd0, o_dv}, {31'd0, mphase[i] == 3});
                if (mphase[i] == 3) begin
                    check("dump_data", i, {7'd0, o_dd}, {7'd0, mword[i][midx[i]]});
                    check("dump_last", i, {31'd0, o_dl}, {31'd0, midx[i] == msize[i] - 1});
                end
                if (o_dv && dump_ready && rxn[i] < 16) begin
                    rxw[i][rxn[i]] = o_dd;
                    rxn[i]++;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [7:0] va, input logic [7:0] vb, input logic [8:0] vy);
        a = va; b = vb; y = vy; sample_en = 1'b1;
        cyc();
        sample_en = 1'b0;
    endtask

    function automatic logic busy_of(input int inst);
        return (inst == 0) ? busy_big : busy_sml;
    endfunction

    // mode 0: ready held high; mode 1: ready pattern 1,0,0,1,0,0,...
    task automatic wait_idle(input int inst, input int mode, input int budget);
        int n;
        n = 0;
        while (busy_of(inst) && n < budget) begin
            dump_ready = (mode == 0) || (n % 3 == 0);
            cyc();
            n++;
        end
        check("dump_done", inst, {31'd0, busy_of(inst)}, 32'd0);
        dump_ready = 1'b0;
    endtask

    task automatic start_big_run();
        start_big = 1'b1;
        cyc();
        start_big = 1'b0;
    endtask

    task automatic capture_three();
        start_big_run();
        sample(8'h01, 8'h02, 9'h003);
        sample(8'hFF, 8'h01, 9'h100);
        sample(8'h00, 8'h00, 9'h000);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        start_big = 1'b0; start_sml = 1'b0; stop = 1'b0; sample_en = 1'b0;
        dump_ready = 1'b0; a = 8'd0; b = 8'd0; y = 9'd0;
        rxn[0] = 0; rxn[1] = 0;
        #12;
        check("rst_valid", 0, {31'd0, dv_big}, 32'd0);
        check("rst_data", 0, {7'd0, dd_big}, 32'd0);
        check("rst_count", 0, {21'd0, cnt_big}, 32'd0);
        check("rst_busy", 1, {31'd0, busy_sml}, 32'd0);
        check("rst_full", 1, {31'd0, full_sml}, 32'd0);
        cyc();
        reset = 1'b1;
        cyc();

        // Scenario 1: three samples, ready held high.
        rxn[0] = 0;
        capture_three();
        wait_idle(0, 0, 50);
        check("t1_beats", 0, rxn[0], 32'd3);
        check("t1_w0", 0, {7'd0, rxw[0][0]}, 32'h0020403);
        check("t1_w1", 0, {7'd0, rxw[0][1]}, 32'h1FE0300);
        check("t1_w2", 0, {7'd0, rxw[0][2]}, 32'h0000000);
        check("t1_count", 0, {21'd0, cnt_big}, 32'd3);

        // Scenario 2: same capture, stalled dump.
        rxn[0] = 0;
        capture_three();
        wait_idle(0, 1, 60);
        check("t2_beats", 0, rxn[0], 32'd3);
        check("t2_w0", 0, {7'd0, rxw[0][0]}, 32'h0020403);
        check("t2_w1", 0, {7'd0, rxw[0][1]}, 32'h1FE0300);
        check("t2_w2", 0, {7'd0, rxw[0][2]}, 32'h0000000);

        // Scenario 3: DEPTH=4 overflow, auto dump.
        rxn[1] = 0;
        start_sml = 1'b1;
        cyc();
        start_sml = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            a = 8'(k); b = 8'(k); y = 9'(k); sample_en = 1'b1;
            cyc();
            if (k == 4) check("t3_full", 1, {31'd0, full_sml}, 32'd1);
        end
        sample_en = 1'b0;
        wait_idle(1, 0, 50);
        check("t3_beats", 1, rxn[1], 32'd4);
        check("t3_w3", 1, {7'd0, rxw[1][3]}, 32'h0080804);
        check("t3_count", 1, {29'd0, cnt_sml}, 32'd4);
        check("t3_full_kept", 1, {31'd0, full_sml}, 32'd1);

        // Scenario 4: start then stop with nothing captured.
        rxn[0] = 0;
        dump_ready = 1'b1;
        start_big_run();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("t4_busy", 0, {31'd0, busy_big}, 32'd0);
        check("t4_count", 0, {21'd0, cnt_big}, 32'd0);
        cyc(); cyc();
        check("t4_beats", 0, rxn[0], 32'd0);
        dump_ready = 1'b0;

        // Scenario 5: sample coincident with stop is kept.
        rxn[0] = 0;
        start_big_run();
        sample(8'h10, 8'h20, 9'h030);
        sample(8'h11, 8'h21, 9'h031);
        a = 8'h12; b = 8'h34; y = 9'h056; sample_en = 1'b1; stop = 1'b1;
        cyc();
        sample_en = 1'b0; stop = 1'b0;
        check("t5_count", 0, {21'd0, cnt_big}, 32'd3);
        wait_idle(0, 0, 50);
        check("t5_beats", 0, rxn[0], 32'd3);
        check("t5_w2", 0, {7'd0, rxw[0][2]}, 32'h0246856);

        // Scenario 6: reset during a stalled second beat, then a clean rerun.
        rxn[0] = 0;
        capture_three();
        dump_ready = 1'b1;
        for (int n = 0; n < 10 && rxn[0] < 1; n++) cyc();
        dump_ready = 1'b0;
        check("t6_first", 0, rxn[0], 32'd1);
        cyc();
        check("t6_stall_valid", 0, {31'd0, dv_big}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("t6_valid", 0, {31'd0, dv_big}, 32'd0);
        check("t6_count", 0, {21'd0, cnt_big}, 32'd0);
        check("t6_full", 0, {31'd0, full_big}, 32'd0);
        check("t6_busy", 0, {31'd0, busy_big}, 32'd0);
        cyc();
        reset = 1'b1;
        cyc();
        rxn[0] = 0;
        start_big_run();
        sample(8'h05, 8'h06, 9'h007);
        sample(8'h08, 8'h09, 9'h00A);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        wait_idle(0, 0, 50);
        check("t6_beats", 0, rxn[0], 32'd2);
        check("t6_w0", 0, {7'd0, rxw[0][0]}, 32'h00A0C07);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
